// File: rtl/tile_pkg.sv
// Shared constants, types and helpers for the tile line buffer.
package tile_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_TOTAL  = 800;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;
   localparam int NUM_COLS = 40;
   localparam int TILE_W   = 16;
   localparam int PIX_W    = 16;
   localparam int ROW_W    = TILE_W * PIX_W;
   localparam int COL_W    = 6;

   typedef logic [PIX_W-1:0] pixel_t;
   typedef logic [ROW_W-1:0] tile_row_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      READY
   } lb_state_t;

   // Pixel k of a tile row, counted from the left; pixel 0 sits in the top bits.
   function automatic pixel_t pick_pixel(input tile_row_t row, input logic [3:0] k);
      pixel_t [TILE_W-1:0] pix;
      pix = row;
      return pix[4'(TILE_W-1) - k];
   endfunction

endpackage

// File: rtl/lb_bank.sv
// One line-buffer bank: NUM_COLS tile rows, one write port, one registered read port.
// Contents are deliberately not reset; every line is rewritten before it is shown.
module lb_bank
   import tile_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [COL_W-1:0] waddr,
   input  tile_row_t        wdata,
   input  logic [COL_W-1:0] raddr,
   output tile_row_t        rdata
);

   tile_row_t mem [NUM_COLS];

   // Write on we, and always read the addressed row one cycle later.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/tile_line_buffer.sv
// Ping-pong line buffer between the tile fetch engine and the VGA pixel path.
// One bank is filled with the next line's tile rows while the other is streamed out.
// Optional macro TILE_LB_LATE_CNT_EN enables the saturating late-fill counter late_cnt;
// without it late_cnt is tied to zero.
module tile_line_buffer
   import tile_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       hcount,
   input  logic [9:0]       vcount,
   output logic             tile_start,
   input  logic [COL_W-1:0] tile_col,
   input  tile_row_t        tile_data,
   input  logic             wren_tile_draw,
   input  logic             tile_done,
   output pixel_t           pixel_out,
   output logic             pixel_valid,
   output logic             fill_late,
   output logic [7:0]       late_cnt
);

   lb_state_t        state;
   lb_state_t        state_nxt;
   logic             wr_sel;
   logic             swap;
   logic             active;
   logic             start_req;
   logic             wr_en;
   logic             late_swap;
   logic [1:0]       bank_we;
   logic [COL_W-1:0] rd_addr;
   tile_row_t        rd_data0;
   tile_row_t        rd_data1;
   logic             rd_sel_d1;
   logic [3:0]       slice_d1;
   logic             valid_d1;

   assign swap    = (hcount == 10'(H_TOTAL - 1));
   assign active  = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
   assign rd_addr = (hcount < 10'(H_ACTIVE)) ? hcount[9:4] : '0;
   assign bank_we = {wr_en & wr_sel, wr_en & ~wr_sel};

   // Next state: the end-of-line swap overrides everything and always returns to IDLE.
   always_comb begin
      state_nxt = state;
      if (swap) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (hcount == 10'(H_ACTIVE)) state_nxt = FILL;
            FILL:    if (tile_done && !tile_start && !wren_tile_draw) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Decoded controls: start request, accepted writes, and a swap that catches a fill in progress.
   always_comb begin
      start_req = (state == IDLE) && (hcount == 10'(H_ACTIVE)) && !swap;
      wr_en     = (state == FILL) && wren_tile_draw && (tile_col < 6'(NUM_COLS)) && !reset;
      late_swap = swap && (state == FILL);
   end

   // State, bank select, start pulse and the sticky late flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_sel     <= 1'b0;
         tile_start <= 1'b0;
         fill_late  <= 1'b0;
      end else begin
         state      <= state_nxt;
         tile_start <= start_req;
         if (swap) begin
            wr_sel <= ~wr_sel;
         end
         if (late_swap) begin
            fill_late <= 1'b1;
         end
      end
   end

`ifdef TILE_LB_LATE_CNT_EN
   // Count every swap that finds the fill still running, saturating at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         late_cnt <= '0;
      end else if (late_swap && (late_cnt != 8'hFF)) begin
         late_cnt <= late_cnt + 8'd1;
      end
   end
`else
   assign late_cnt = '0;
`endif

   lb_bank u_bank0 (
      .clk   (clk),
      .we    (bank_we[0]),
      .waddr (tile_col),
      .wdata (tile_data),
      .raddr (rd_addr),
      .rdata (rd_data0)
   );

   lb_bank u_bank1 (
      .clk   (clk),
      .we    (bank_we[1]),
      .waddr (tile_col),
      .wdata (tile_data),
      .raddr (rd_addr),
      .rdata (rd_data1)
   );

   // Read pipeline: bank and slice travel with the address so a swap cannot tear a line.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_sel_d1   <= 1'b0;
         slice_d1    <= '0;
         valid_d1    <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_out   <= '0;
      end else begin
         rd_sel_d1   <= ~wr_sel;
         slice_d1    <= hcount[3:0];
         valid_d1    <= active;
         pixel_valid <= valid_d1;
         pixel_out   <= valid_d1 ? pick_pixel(rd_sel_d1 ? rd_data1 : rd_data0, slice_d1) : '0;
      end
   end

endmodule

// File: tb/tb_tile_line_buffer.sv
// Scoreboard bench for tile_line_buffer: the bench plays the tile engine and the
// VGA timing, queues expected pixels, and a negedge monitor checks them.
module tb_tile_line_buffer;
   import tile_pkg::*;

   localparam int M_NONE = 0;
   localparam int M_FULL = 1;
   localparam int M_LATE = 2;
   localparam int M_RST  = 3;

   typedef struct {
      int     h;
      pixel_t pix;
   } exp_t;

   logic             clk;
   logic             reset;
   logic [9:0]       hcount;
   logic [9:0]       vcount;
   logic             tile_start;
   logic [COL_W-1:0] tile_col;
   tile_row_t        tile_data;
   logic             wren_tile_draw;
   logic             tile_done;
   pixel_t           pixel_out;
   logic             pixel_valid;
   logic             fill_late;
   logic [7:0]       late_cnt;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   bit   mon_en       = 1'b0;

`ifdef TILE_LB_LATE_CNT_EN
   localparam int LATE_ONE = 1;
`else
   localparam int LATE_ONE = 0;
`endif

   tile_line_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .hcount         (hcount),
      .vcount         (vcount),
      .tile_start     (tile_start),
      .tile_col       (tile_col),
      .tile_data      (tile_data),
      .wren_tile_draw (wren_tile_draw),
      .tile_done      (tile_done),
      .pixel_out      (pixel_out),
      .pixel_valid    (pixel_valid),
      .fill_late      (fill_late),
      .late_cnt       (late_cnt)
   );

   // Free-running pixel clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference pixel k of column c for each test pattern.
   function automatic pixel_t expPix(input int pat, input int c, input int k);
      logic [7:0] cb;
      cb = 8'(c);
      case (pat)
         0:       return {cb, 8'(cb + 8'h80)};
         1:       return (c == 3) ? 16'hA000 + 16'(k) : {2'b01, 6'(c), 4'h0, 4'(k)};
         2:       return {4'hC, 6'(c), 2'b00, 4'(k)};
         default: return (c < 20) ? {4'hC, 6'(c), 2'b00, 4'(k)} : {2'b01, 6'(c), 4'h0, 4'(k)};
      endcase
   endfunction

   // Tile row whose leftmost pixel occupies [255:240].
   function automatic tile_row_t makeRow(input int pat, input int c);
      tile_row_t r;
      r = '0;
      for (int k = 0; k < TILE_W; k++) begin
         r[255 - 16*k -: 16] = expPix(pat, c, k);
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input int h, input int v, input logic wr,
                                input int col, input tile_row_t data);
      reset          = rst;
      hcount         = 10'(h);
      vcount         = 10'(v);
      wren_tile_draw = wr;
      tile_col       = 6'(col);
      tile_data      = data;
   endtask

   // Monitor: pops one expectation per valid pixel and checks gating otherwise.
   always @(negedge clk) begin
      if (mon_en) begin
         if (pixel_valid === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL unexpected_pixel: got %0h at hcount %0d, expected none", pixel_out, hcount);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (pixel_out !== e.pix || int'(hcount) != e.h + 2) begin
                  tests_failed++;
                  $display("[TB] FAIL pixel_h%0d: got %0h at hcount %0d, expected %0h at hcount %0d",
                           e.h, pixel_out, hcount, e.pix, e.h + 2);
               end
            end
         end else begin
            tests_run++;
            if (pixel_out !== 16'h0 || pixel_valid !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL gated_pixel: got out=%0h valid=%b, expected 0/0", pixel_out, pixel_valid);
            end
         end
      end
   end

   // One full scanline: drives timing, plays the engine, and queues expected pixels.
   task automatic runLine(input int vc, input int mode, input int pat, input int show_pat, input int junk_col);
      int        starts;
      int        start_h;
      int        eng_idx;
      bit        eng_busy;
      bit        did_rst;
      bit        rst_pending;
      logic      rst;
      logic      wr;
      int        col;
      tile_row_t data;
      exp_t      e;
      starts      = 0;
      start_h     = -1;
      eng_idx     = 0;
      eng_busy    = 1'b0;
      did_rst     = 1'b0;
      rst_pending = 1'b0;
      tile_done   = 1'b1;
      for (int h = 0; h < H_TOTAL; h++) begin
         @(posedge clk);
         #1;
         if (tile_start === 1'b1) begin
            starts++;
            start_h = int'(hcount);
            if (mode != M_NONE) begin
               eng_busy  = 1'b1;
               eng_idx   = 0;
               tile_done = 1'b0;
            end
         end
         if (rst_pending) begin
            rst_pending = 1'b0;
            checkOutput("rst_fill_late", 32'(fill_late), 32'd0);
            checkOutput("rst_late_cnt", 32'(late_cnt), 32'd0);
            checkOutput("rst_tile_start", 32'(tile_start), 32'd0);
         end
         rst  = 1'b0;
         wr   = 1'b0;
         col  = 0;
         data = '0;
         if (eng_busy) begin
            if (mode == M_RST && eng_idx == 20 && !did_rst) begin
               rst         = 1'b1;
               did_rst     = 1'b1;
               rst_pending = 1'b1;
            end else if (eng_idx < NUM_COLS) begin
               wr   = 1'b1;
               col  = eng_idx;
               data = makeRow(pat, eng_idx);
               eng_idx++;
            end else begin
               eng_busy = 1'b0;
               if (mode != M_LATE) tile_done = 1'b1;
            end
         end
         if (junk_col >= 0 && h >= 100 && h < 104) begin
            wr   = 1'b1;
            col  = junk_col;
            data = makeRow(2, junk_col);
         end
         applyStimulus(rst, h, vc, wr, col, data);
         if (vc < V_ACTIVE && h < H_ACTIVE) begin
            e.h   = h;
            e.pix = expPix(show_pat, h / TILE_W, h % TILE_W);
            exp_q.push_back(e);
         end
      end
      checkOutput($sformatf("start_count_v%0d", vc), 32'(starts), 32'd1);
      checkOutput($sformatf("start_hcount_v%0d", vc), 32'(start_h), 32'd640);
   endtask

   initial begin
      applyStimulus(1'b1, 636, 0, 1'b1, 1, makeRow(0, 1));
      tile_done = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (i > 0) begin
            checkOutput("reset_tile_start", 32'(tile_start), 32'd0);
            checkOutput("reset_pixel_valid", 32'(pixel_valid), 32'd0);
            checkOutput("reset_pixel_out", 32'(pixel_out), 32'd0);
            checkOutput("reset_fill_late", 32'(fill_late), 32'd0);
            checkOutput("reset_late_cnt", 32'(late_cnt), 32'd0);
         end
         applyStimulus(1'b1, 637 + i, 0, 1'b1, 1, makeRow(0, 1));
      end
      mon_en = 1'b1;

      runLine(500, M_NONE, 0, -1, -1);
      runLine(524, M_FULL, 0, -1, -1);
      runLine(0,   M_FULL, 1,  0, -1);
      runLine(1,   M_LATE, 0,  1, -1);
      checkOutput("fill_late_before_swap", 32'(fill_late), 32'd0);
      runLine(2,   M_NONE, 0,  0, 25);
      checkOutput("fill_late_after_late", 32'(fill_late), 32'd1);
      checkOutput("late_cnt_after_late", 32'(late_cnt), 32'(LATE_ONE));
      runLine(500, M_NONE, 0, -1, -1);
      checkOutput("fill_late_sticky", 32'(fill_late), 32'd1);
      runLine(510, M_RST,  2, -1, -1);
      checkOutput("fill_late_post_reset", 32'(fill_late), 32'd0);
      runLine(0,   M_NONE, 0,  3, -1);
      checkOutput("fill_late_final", 32'(fill_late), 32'd0);
      checkOutput("late_cnt_final", 32'(late_cnt), 32'd0);

      @(posedge clk);
      #1;
      applyStimulus(1'b0, 0, 500, 1'b0, 0, '0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
